vga_fb_scan_arbiter: RTL

//  Shares one single-port framebuffer RAM between VGA scan-out and a drawing client.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_pipe_delay.sv | 36 +++
 rtl/vga_fb_scan_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and framebuffer geometry for the scan-out path.
// The framebuffer is a 4x downscaled 160x120 image, double-buffered by an address page bit.
package vga_timing_pkg;

  localparam int H_PIX    = 640;
  localparam int H_SYNC_S = 659;
  localparam int H_SYNC_E = 754;
  localparam int H_TOTAL  = 800;
  localparam int V_PIX    = 480;
  localparam int V_SYNC_S = 493;
  localparam int V_SYNC_E = 494;
  localparam int V_TOTAL  = 525;

  localparam int SHIFT = 2;
  localparam int FB_W  = H_PIX >> SHIFT;
  localparam int FB_H  = V_PIX >> SHIFT;

  localparam int COLOR_W = 9;
  localparam int ADDR_W  = 16;
  localparam int IDX_W   = ADDR_W - 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

  // Row-major pixel index; 160x120 never exceeds 15 bits, so no wrap handling is needed.
  function automatic logic [IDX_W-1:0] fb_index(input logic [IDX_W-1:0] col,
                                                input logic [IDX_W-1:0] row);
    return row * IDX_W'(FB_W) + col;
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// N-stage register delay line with a per-bit reset value, used to align the
// timing flags with the pixel that comes back from the framebuffer RAM.
module vga_pipe_delay #(
  parameter int           W       = 1,
  parameter int           N       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         vga_clock,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [N];
  logic [W-1:0] stage_d [N];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < N; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_fb_scan_arbiter.sv
// Shares one single-port framebuffer between scan-out reads (active region) and draw
// writes (blanking), with front/back page flipping at the start of vertical blank.
module vga_fb_scan_arbiter
  import vga_timing_pkg::*;
(
  input  logic               vga_clock,
  input  logic               resetn,
  input  logic [9:0]         xCounter,
  input  logic [9:0]         yCounter,
  input  logic               draw_valid,
  output logic               draw_ready,
  input  logic [7:0]         draw_x,
  input  logic [6:0]         draw_y,
  input  logic [COLOR_W-1:0] draw_color,
  input  logic               swap_req,
  output logic               swap_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n
);

  logic             active, in_range, grant, flip_point;
  logic             hs_now, vs_now;
  logic [IDX_W-1:0] scan_idx, draw_idx;

  assign active     = (xCounter < 10'(H_PIX)) && (yCounter < 10'(V_PIX));
  assign draw_ready = resetn && !active;
  assign grant      = draw_valid && draw_ready;
  assign in_range   = (draw_x < 8'(FB_W)) && (draw_y < 7'(FB_H));
  assign flip_point = (xCounter == 10'(H_TOTAL - 1)) && (yCounter == 10'(V_PIX - 1));
  assign hs_now     = !((xCounter >= 10'(H_SYNC_S)) && (xCounter <= 10'(H_SYNC_E)));
  assign vs_now     = !((yCounter >= 10'(V_SYNC_S)) && (yCounter <= 10'(V_SYNC_E)));
  assign scan_idx   = fb_index(IDX_W'(xCounter >> SHIFT), IDX_W'(yCounter >> SHIFT));
  assign draw_idx   = fb_index(IDX_W'(draw_x), IDX_W'(draw_y));

  swap_state_e        state_q, state_d;
  logic               front_q, front_d;
  logic               swap_done_q, swap_done_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [COLOR_W-1:0] vga_color_q, vga_color_d;
  logic               vga_hs_q, vga_hs_d;
  logic               vga_vs_q, vga_vs_d;
  logic               vga_blank_n_q, vga_blank_n_d;
  logic               hs_d2, vs_d2, active_d2;

  // Grant stage: each cycle is either a front-page read slot or a back-page write slot.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (active) begin
      mem_addr_d = {front_q, scan_idx};
    end else if (grant && in_range) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {~front_q, draw_idx};
      mem_wdata_d = draw_color;
    end
  end

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flip_point && swap_req) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
        end else if (swap_req) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (flip_point) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  vga_pipe_delay #(
    .W       (3),
    .N       (2),
    .RST_VAL (3'b110)
  ) u_timing_delay (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .din       ({hs_now, vs_now, active}),
    .dout      ({hs_d2, vs_d2, active_d2})
  );

  // Third stage pairs the returned pixel with its own timing flags.
  always_comb begin
    vga_color_d   = active_d2 ? mem_rdata : '0;
    vga_hs_d      = hs_d2;
    vga_vs_d      = vs_d2;
    vga_blank_n_d = active_d2;
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      front_q       <= 1'b0;
      swap_done_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      vga_color_q   <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      swap_done_q   <= swap_done_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      vga_color_q   <= vga_color_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_n_q <= vga_blank_n_d;
    end
  end

  assign swap_done   = swap_done_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign vga_color   = vga_color_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_blank_n = vga_blank_n_q;

endmodule
